instr_exec_unit: RTL
====================

// Module: instr_exec_unit
// PURPOSE
// - Downstream consumer of the instruction register. Walks read_pointer over a block of stored
//   instructions and fetches each instruction_word (opcode, operand_a, operand_b).
// - Executes each one and presents a 64-bit signed result per instruction.
// - Output is a valid/ready handshake; the result sink (scoreboard/writeback) can stall it.
// PARAMETERS
// - ADDR_W   5   width of address_t; register depth is 2**ADDR_W
// - DATA_W  32   width of operand_t (signed)
// - RES_W   64   result width; must be >= 2*DATA_W
// PORTS
// - clk               in   1         clock, all state on posedge
// - reset             in   1         asynchronous, active-high; clears all state
// - start             in   1         1-cycle request; ignored while busy=1
// - first_ptr         in   ADDR_W    address of first instruction, sampled with start
// - num_instr         in   ADDR_W+1  instructions to run (0..32), sampled with start
// - read_pointer      out  ADDR_W    read address to the instruction register
// - instruction_word  in   instr_t   combinational read data for read_pointer
// - busy              out  1         high from the cycle after an accepted start until done
// - res_valid         out  1         result available
// - res_ready         in   1         sink accepts when res_valid & res_ready
// - res_ptr           out  ADDR_W    address the result came from
// - res_opc           out  3         opcode executed
// - result            out  RES_W     signed result
// - res_err           out  1         divide/modulo by zero (or op compiled out)
// - done              out  1         1-cycle pulse after the last result is accepted
// BEHAVIOUR
// - Reset values: read_pointer=0, busy=0, res_valid=0, res_ptr=0, res_opc=0, result=0,
//   res_err=0, done=0. FSM=IDLE.
// - Reset asserted mid-run aborts immediately. No partial result, no done.
// - FSM states and transitions:
//   - IDLE: start & num_instr!=0 -> FETCH, load ptr=first_ptr and cnt=num_instr.
//     start & num_instr==0 -> done pulse next cycle, stay IDLE.
//   - FETCH (1 cycle): latch instruction_word -> EXEC.
//   - EXEC: single-cycle ops -> OUT next cycle. DIV/MOD use an iterative restoring divider on
//     magnitudes: 32 iterations + 1 sign-fix cycle, then OUT.
//   - OUT: res_valid=1. All res_* outputs stay stable until res_ready.
//     On handshake: cnt-1 and ptr+1 (wraps 31->0).
//     If cnt was 1 -> IDLE with done=1 for 1 cycle, otherwise -> FETCH.
// - Latency from the start edge to res_valid high: 3 clocks for single-cycle ops,
//   35 clocks for DIV/MOD. Per-instruction throughput is >= 3 cycles.
// - Opcodes (package encoding):
//   - ZERO=0 -> 0
//   - PASSA=1 -> a; PASSB=2 -> b
//   - ADD=3 -> a+b; SUB=4 -> a-b (operands sign-extended to RES_W, no overflow possible)
//   - MULT=5 -> full signed a*b
//   - DIV=6 -> quotient truncated toward zero
//   - MOD=7 -> remainder with the sign of a (SV % semantics)
//   - -2^31 / -1 = +2^31 exactly in RES_W.
// - b==0 on DIV/MOD: EXEC takes 1 cycle, result=0, res_err=1. res_err=0 for all other ops.
// - start while busy is ignored and not queued.
// - read_pointer equals the internal ptr in every state; it is held while in OUT.
// CONFIGURATION
// - Macro EXEC_DIV_EN.
// - Defined: iterative divider present; DIV/MOD behave as above.
// - Undefined: no divider logic. DIV/MOD complete in 1 EXEC cycle with result=0, res_err=1.
//   All other ops are unchanged.
// TESTING
// - Reset, then IDLE: all outputs 0. Assert reset mid-DIV (cycle 10 of EXEC): busy=0 and
//   res_valid=0 next cycle.
// - ADD a=5 b=-7 at addr 0, start num_instr=1, res_ready=1: res_valid at clock 3,
//   result=-2, res_ptr=0, done 1 cycle after the handshake.
// - MULT a=-2^31 b=-2^31: result=2^62. PASSB b=123: result=123.
//   DIV a=-7 b=2: result=-3. MOD a=-7 b=2: result=-1. DIV a=9 b=0: result=0, res_err=1.
// - first_ptr=30, num_instr=4: read_pointer sequence 30,31,0,1; exactly 4 handshakes, then done.
// - Hold res_ready=0 for 10 cycles in OUT: res_* stable, read_pointer unchanged.
//   A start pulse during this stall is ignored.
// - Compile without EXEC_DIV_EN: DIV a=9 b=3 -> result=0, res_err=1, res_valid at clock 3.

Source files
------------

// File: rtl/instr_exec_unit_if.sv
// Instruction-fetch and result bus for instr_exec_unit.
//
// Purpose: groups the instruction-register read port and the result valid/ready handshake.
//   read_pointer      master->slave  address into the instruction register
//   instruction_word  slave->master  combinational read data: {opcode[2:0], operand_a, operand_b}
//   res_valid         master->slave  result available
//   res_ready         slave->master  sink accepts when res_valid & res_ready
//   res_ptr           master->slave  address the result came from
//   res_opc           master->slave  opcode executed
//   result            master->slave  signed result, RES_W bits
//   res_err           master->slave  divide/modulo by zero, or divider compiled out
interface instr_exec_unit_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RES_W  = 64
);
   localparam int unsigned INSTR_W = 3 + 2 * DATA_W;

   logic [ADDR_W-1:0]  read_pointer;
   logic [INSTR_W-1:0] instruction_word;
   logic               res_valid;
   logic               res_ready;
   logic [ADDR_W-1:0]  res_ptr;
   logic [2:0]         res_opc;
   logic [RES_W-1:0]   result;
   logic               res_err;

   modport master (
      output read_pointer,
      input  instruction_word,
      output res_valid,
      input  res_ready,
      output res_ptr,
      output res_opc,
      output result,
      output res_err
   );

   modport slave (
      input  read_pointer,
      output instruction_word,
      input  res_valid,
      output res_ready,
      input  res_ptr,
      input  res_opc,
      input  result,
      input  res_err
   );
endinterface

// File: rtl/instr_exec_unit.sv
// Instruction execution unit.
//
// Purpose: walks read_pointer over num_instr stored instructions starting at first_ptr,
// fetches each instruction_word, executes it and presents one signed result per instruction
// on a valid/ready handshake. A done pulse follows the last accepted result.
//
// Ports:
//   clk        clock, all state on posedge
//   reset      asynchronous, active-high; clears all state
//   start      1-cycle request, ignored while busy
//   first_ptr  first instruction address, sampled with start
//   num_instr  instruction count 0..2**ADDR_W, sampled with start
//   busy       high from the cycle after an accepted start until done
//   done       1-cycle pulse after the last result is accepted
//   bus        instruction read port and result handshake (instr_exec_unit_if.master)
//
// Build option: define EXEC_DIV_EN to include the iterative restoring divider. Without it,
// DIV/MOD finish in one EXEC cycle with result=0 and res_err=1.
module instr_exec_unit #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RES_W  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_ptr,
   input  logic [ADDR_W:0]   num_instr,
   output logic              busy,
   output logic              done,
   instr_exec_unit_if.master bus
);

   typedef enum logic [2:0] {
      OpZero  = 3'd0,
      OpPassA = 3'd1,
      OpPassB = 3'd2,
      OpAdd   = 3'd3,
      OpSub   = 3'd4,
      OpMult  = 3'd5,
      OpDiv   = 3'd6,
      OpMod   = 3'd7
   } opcode_e;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StExec,
      StOut
   } state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   ptr_q;
   logic [ADDR_W:0]     cnt_q;
   opcode_e             opc_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   logic                busy_q;
   logic                done_q;
   logic                res_valid_q;
   logic [ADDR_W-1:0]   res_ptr_q;
   logic [2:0]          res_opc_q;
   logic [RES_W-1:0]    result_q;
   logic                res_err_q;

   // Instruction word fields: {opcode, operand_a, operand_b}
   opcode_e           fetch_opc;
   logic [DATA_W-1:0] fetch_a;
   logic [DATA_W-1:0] fetch_b;

   assign fetch_opc = opcode_e'(bus.instruction_word[2*DATA_W+2:2*DATA_W]);
   assign fetch_a   = bus.instruction_word[2*DATA_W-1:DATA_W];
   assign fetch_b   = bus.instruction_word[DATA_W-1:0];

   // Single-cycle ALU. Operands are sign-extended to RES_W so ADD/SUB cannot overflow and the
   // low RES_W bits of the product are the exact signed product.
   logic signed [RES_W-1:0] a_ext;
   logic signed [RES_W-1:0] b_ext;
   logic        [RES_W-1:0] alu_res;
   logic                    is_div_op;

   assign a_ext     = {{(RES_W-DATA_W){a_q[DATA_W-1]}}, a_q};
   assign b_ext     = {{(RES_W-DATA_W){b_q[DATA_W-1]}}, b_q};
   assign is_div_op = (opc_q == OpDiv) || (opc_q == OpMod);

   always_comb begin
      alu_res = '0;
      unique case (opc_q)
         OpPassA: alu_res = a_ext;
         OpPassB: alu_res = b_ext;
         OpAdd:   alu_res = a_ext + b_ext;
         OpSub:   alu_res = a_ext - b_ext;
         OpMult:  alu_res = a_ext * b_ext;
         default: alu_res = '0;
      endcase
   end

`ifdef EXEC_DIV_EN
   localparam int unsigned IterW = $clog2(DATA_W + 1);

   // Restoring divider on magnitudes; signs are applied in one extra cycle at the end.
   logic [DATA_W-1:0] quo_q;
   logic [DATA_W-1:0] rem_q;
   logic [DATA_W-1:0] dvsr_q;
   logic [IterW-1:0]  iter_q;
   logic              neg_quo_q;
   logic              neg_rem_q;
   logic [DATA_W:0]   rem_shift;
   logic [DATA_W:0]   rem_sub;
   logic              take;
   logic [DATA_W-1:0] mag_a;
   logic [DATA_W-1:0] mag_b;
   logic [RES_W-1:0]  quo_ext;
   logic [RES_W-1:0]  rem_ext;
   logic [RES_W-1:0]  div_res;

   assign mag_a     = fetch_a[DATA_W-1] ? (~fetch_a + 1'b1) : fetch_a;
   assign mag_b     = fetch_b[DATA_W-1] ? (~fetch_b + 1'b1) : fetch_b;
   assign rem_shift = {rem_q, quo_q[DATA_W-1]};
   assign rem_sub   = rem_shift - {1'b0, dvsr_q};
   // rem_shift < 2*divisor, so the subtraction borrows exactly when rem_shift < divisor.
   assign take      = ~rem_sub[DATA_W];
   assign quo_ext   = {{(RES_W-DATA_W){1'b0}}, quo_q};
   assign rem_ext   = {{(RES_W-DATA_W){1'b0}}, rem_q};
   assign div_res   = (opc_q == OpDiv) ? (neg_quo_q ? (~quo_ext + 1'b1) : quo_ext)
                                       : (neg_rem_q ? (~rem_ext + 1'b1) : rem_ext);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         cnt_q       <= '0;
         opc_q       <= OpZero;
         a_q         <= '0;
         b_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_ptr_q   <= '0;
         res_opc_q   <= '0;
         result_q    <= '0;
         res_err_q   <= 1'b0;
`ifdef EXEC_DIV_EN
         quo_q       <= '0;
         rem_q       <= '0;
         dvsr_q      <= '0;
         iter_q      <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (num_instr != '0) begin
                     ptr_q   <= first_ptr;
                     cnt_q   <= num_instr;
                     busy_q  <= 1'b1;
                     state_q <= StFetch;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            StFetch: begin
               opc_q   <= fetch_opc;
               a_q     <= fetch_a;
               b_q     <= fetch_b;
`ifdef EXEC_DIV_EN
               quo_q     <= mag_a;
               rem_q     <= '0;
               dvsr_q    <= mag_b;
               iter_q    <= '0;
               neg_quo_q <= fetch_a[DATA_W-1] ^ fetch_b[DATA_W-1];
               neg_rem_q <= fetch_a[DATA_W-1];
`endif
               state_q <= StExec;
            end
            StExec: begin
               res_ptr_q <= ptr_q;
               res_opc_q <= opc_q;
               if (is_div_op) begin
`ifdef EXEC_DIV_EN
                  if (b_q == '0) begin
                     result_q    <= '0;
                     res_err_q   <= 1'b1;
                     res_valid_q <= 1'b1;
                     state_q     <= StOut;
                  end else if (iter_q != IterW'(DATA_W)) begin
                     quo_q  <= {quo_q[DATA_W-2:0], take};
                     rem_q  <= take ? rem_sub[DATA_W-1:0] : rem_shift[DATA_W-1:0];
                     iter_q <= iter_q + 1'b1;
                  end else begin
                     result_q    <= div_res;
                     res_err_q   <= 1'b0;
                     res_valid_q <= 1'b1;
                     state_q     <= StOut;
                  end
`else
                  result_q    <= '0;
                  res_err_q   <= 1'b1;
                  res_valid_q <= 1'b1;
                  state_q     <= StOut;
`endif
               end else begin
                  result_q    <= alu_res;
                  res_err_q   <= 1'b0;
                  res_valid_q <= 1'b1;
                  state_q     <= StOut;
               end
            end
            StOut: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  ptr_q       <= ptr_q + 1'b1;
                  cnt_q       <= cnt_q - 1'b1;
                  if (cnt_q == (ADDR_W+1)'(1)) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     state_q <= StFetch;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.read_pointer = ptr_q;
   assign bus.res_valid    = res_valid_q;
   assign bus.res_ptr      = res_ptr_q;
   assign bus.res_opc      = res_opc_q;
   assign bus.result       = result_q;
   assign bus.res_err      = res_err_q;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule
